// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/operand/result bundle between requester and serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] input_1;
  logic [WIDTH-1:0] input_2;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   borrow;
  modport master (output start, input_1, input_2, b_in, input busy, done, diff, borrow);
  modport slave  (input start, input_1, input_2, b_in, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first subtractor, one bit per cycle, full borrow chain reported
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int W1 = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [W1-1:0]    d_acc, c_acc;
  logic             br0, br_cur;
  logic             accept, d_bit, br_next;
  assign accept  = bus.start && (state == IDLE || state == DONE);
  assign d_bit   = a_sr[0] ^ b_sr[0] ^ br_cur;
  assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br_cur);
  assign bus.busy = state == SHIFT;
  assign bus.done = state == DONE;
  // partial difference/borrow bits collect in d_acc/c_acc; outputs load only on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      br0        <= 1'b0;
      br_cur     <= 1'b0;
      d_acc      <= '0;
      c_acc      <= '0;
      bus.diff   <= '0;
      bus.borrow <= '0;
    end else if (accept) begin
      state  <= SHIFT;
      cnt    <= '0;
      a_sr   <= bus.input_1;
      b_sr   <= bus.input_2;
      br0    <= bus.b_in;
      br_cur <= bus.b_in;
      d_acc  <= '0;
      c_acc  <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      br_cur <= br_next;
      d_acc  <= W1'({d_bit, d_acc} >> 1);
      c_acc  <= W1'({br_next, c_acc} >> 1);
      cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (cnt == LAST) begin
        state      <= DONE;
        bus.diff   <= {d_bit, d_acc};
        bus.borrow <= {br_next, c_acc, br0};
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule
